// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman array controller.
package sw_pkg;

    localparam int unsigned SC_WORD_W   = 32;
    localparam int unsigned MAXFLAG_BIT = 31;

    typedef logic [1:0] sym_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSettle,
        StDrain,
        StFlush,
        StDone
    } sw_ctrl_state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sw_score_drain.sv
// Serialises PE scores into the score FIFO, one word per non-full cycle.
// Optional running-max tracker and trailing max word under SW_MAX_TRACK_EN.
module sw_score_drain
    import sw_pkg::*;
#(
    parameter int unsigned DEPTH    = 50,
    parameter int unsigned SCORE_W  = 16,
    parameter int unsigned OUT_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     active,
    input  logic                     final_req,
    input  logic                     full,
    input  logic [DEPTH*SCORE_W-1:0] scores,
    output logic [SC_WORD_W-1:0]     data,
    output logic                     wren,
    output logic                     done,
    output logic                     final_done
);

    localparam int unsigned   IW    = cnt_w(DEPTH);
    localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] FIRST = (OUT_MODE == 1) ? LAST : '0;

    logic [IW-1:0]        idx_q;
    logic                 done_q;
    logic                 fire;
    logic [SCORE_W-1:0]   score;
    logic [SC_WORD_W-1:0] score_word;

    always_comb begin
        score = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (idx_q == IW'(k)) score = scores[k*SCORE_W +: SCORE_W];
        end
    end

    assign score_word = SC_WORD_W'(score);
    // done_q blocks a second pass while the FSM leaves DRAIN
    assign fire       = active && !done_q && !full;
    assign done       = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= FIRST;
            done_q <= 1'b0;
        end else if (clear) begin
            idx_q  <= FIRST;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fire) begin
                if (idx_q == LAST) begin
                    idx_q  <= FIRST;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

`ifdef SW_MAX_TRACK_EN
    logic [SCORE_W-1:0]   max_q;
    logic                 final_sent_q;
    logic                 final_fire;
    logic [SC_WORD_W-1:0] max_word;

    assign final_fire = final_req && !final_sent_q && !full;

    always_comb begin
        max_word              = SC_WORD_W'(max_q);
        max_word[MAXFLAG_BIT] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q        <= '0;
            final_sent_q <= 1'b0;
        end else if (clear) begin
            max_q        <= '0;
            final_sent_q <= 1'b0;
        end else begin
            if (fire && (score > max_q)) max_q <= score;
            if (final_fire) final_sent_q <= 1'b1;
        end
    end

    assign wren       = fire || final_fire;
    assign data       = fire ? score_word : (final_fire ? max_word : '0);
    assign final_done = final_sent_q;
`else
    logic unused_final_req;
    assign unused_final_req = final_req;

    assign wren       = fire;
    assign data       = fire ? score_word : '0;
    assign final_done = 1'b1;
`endif

endmodule

// File: rtl/sw_array_ctrl.sv
// Smith-Waterman PE array controller: symbol steps, enable ramp/flush, score drain, EOF.
// Build option SW_MAX_TRACK_EN adds a trailing running-max word before EOF.
module sw_array_ctrl
    import sw_pkg::*;
#(
    parameter int unsigned DEPTH    = 50,
    parameter int unsigned SCORE_W  = 16,
    parameter int unsigned PE_LAT   = 1,
    parameter int unsigned OUT_MODE = 0
) (
    input  logic                     bus_clk,
    input  logic                     quiesce,
    input  logic                     run_i,
    input  logic [1:0]               sym_i,
    input  logic                     sym_valid_i,
    output logic                     sym_ready_o,
    input  logic                     src_done_i,
    output logic [1:0]               pe_y_o,
    output logic                     pe_y_valid_o,
    output logic [DEPTH-1:0]         pe_en_o,
    input  logic [DEPTH*SCORE_W-1:0] pe_score_i,
    output logic [31:0]              sc_data_o,
    output logic                     sc_wren_o,
    input  logic                     sc_full_i,
    input  logic                     sc_empty_i,
    output logic                     eof_o
);

    localparam int unsigned      CW          = cnt_w(DEPTH + 1);
    localparam logic [CW-1:0]    DEPTH_C     = CW'(DEPTH);
    localparam logic [DEPTH-1:0] EN_ONE      = DEPTH'(1);
    localparam logic [3:0]       SETTLE_INIT = 4'(PE_LAT - 1);

    sw_ctrl_state_t   state_q;
    logic [CW-1:0]    ramp_q;
    logic [CW-1:0]    flush_q;
    logic             flush_mode_q;
    logic [3:0]       settle_q;
    sym_t             pe_y_q;
    logic             pe_y_valid_q;
    logic [DEPTH-1:0] pe_en_q;

    logic             ramp_open;
    logic [DEPTH-1:0] ramp_mask;
    logic [DEPTH-1:0] flush_mask;
    logic             drain_active;
    logic             drain_clear;
    logic             drain_done;
    logic             final_req;
    logic             final_done;

    assign ramp_open    = (ramp_q < DEPTH_C);
    assign ramp_mask    = ramp_open ? (EN_ONE << ramp_q) : '0;
    assign flush_mask   = EN_ONE << flush_q;
    assign drain_active = (state_q == StDrain) && run_i;
    assign drain_clear  = (state_q == StIdle) || !run_i;
    assign final_req    = (state_q == StDone) && run_i;

    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            state_q      <= StIdle;
            ramp_q       <= '0;
            flush_q      <= '0;
            flush_mode_q <= 1'b0;
            settle_q     <= '0;
            pe_y_q       <= '0;
            pe_y_valid_q <= 1'b0;
            pe_en_q      <= '0;
        end else if (!run_i) begin
            state_q      <= StIdle;
            ramp_q       <= '0;
            flush_q      <= '0;
            flush_mode_q <= 1'b0;
            settle_q     <= '0;
            pe_y_q       <= '0;
            pe_y_valid_q <= 1'b0;
            pe_en_q      <= '0;
        end else begin
            pe_y_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (sym_valid_i) begin
                        pe_y_q       <= sym_i;
                        pe_y_valid_q <= 1'b1;
                        pe_en_q      <= pe_en_q | ramp_mask;
                        if (ramp_open) ramp_q <= ramp_q + CW'(1);
                        settle_q     <= SETTLE_INIT;
                        state_q      <= StSettle;
                    end else if (src_done_i) begin
                        state_q <= (ramp_q == '0) ? StDone : StFlush;
                    end
                end
                StSettle: begin
                    if (settle_q == '0) state_q <= StDrain;
                    else settle_q <= settle_q - 4'd1;
                end
                StDrain: begin
                    if (drain_done) begin
                        if (!flush_mode_q) state_q <= StFetch;
                        else if (flush_q == DEPTH_C) state_q <= StDone;
                        else state_q <= StFlush;
                    end
                end
                StFlush: begin
                    // retire PE f while the ramp may still be switching on a new PE
                    pe_y_q       <= '0;
                    pe_y_valid_q <= 1'b1;
                    pe_en_q      <= (pe_en_q & ~flush_mask) | ramp_mask;
                    if (ramp_open) ramp_q <= ramp_q + CW'(1);
                    flush_q      <= flush_q + CW'(1);
                    flush_mode_q <= 1'b1;
                    settle_q     <= SETTLE_INIT;
                    state_q      <= StSettle;
                end
                StDone:  state_q <= StDone;
                default: state_q <= StIdle;
            endcase
        end
    end

    sw_score_drain #(
        .DEPTH   (DEPTH),
        .SCORE_W (SCORE_W),
        .OUT_MODE(OUT_MODE)
    ) u_drain (
        .clk       (bus_clk),
        .rst       (quiesce),
        .clear     (drain_clear),
        .active    (drain_active),
        .final_req (final_req),
        .full      (sc_full_i),
        .scores    (pe_score_i),
        .data      (sc_data_o),
        .wren      (sc_wren_o),
        .done      (drain_done),
        .final_done(final_done)
    );

    assign sym_ready_o  = (state_q == StFetch) && run_i;
    assign pe_y_o       = pe_y_q;
    assign pe_y_valid_o = pe_y_valid_q;
    assign pe_en_o      = pe_en_q;
    assign eof_o        = (state_q == StDone) && run_i && sc_empty_i && final_done;

endmodule

// File: tb/tb_sw_array_ctrl.sv
// Directed bench for sw_array_ctrl: DEPTH=4, one OUT_MODE=0 and one OUT_MODE=1 instance.
module tb_sw_array_ctrl;

    logic        clk = 1'b0;
    logic        quiesce, run0, run1, sym_valid, src_done, sc_full, sc_empty;
    logic [1:0]  sym;
    logic [63:0] scores;

    logic        rdy0, yv0, wren0, eof0, rdy1, yv1, wren1, eof1;
    logic [1:0]  y0, y1;
    logic [3:0]  en0, en1;
    logic [31:0] data0, data1;

    int checks = 0;
    int errors = 0;

    logic [31:0] words0[$];
    logic [31:0] words1[$];
    logic [3:0]  ens0[$];
    logic [3:0]  ens1[$];

    always #5 clk = ~clk;

    sw_array_ctrl #(.DEPTH(4), .SCORE_W(16), .PE_LAT(1), .OUT_MODE(0)) u_dut0 (
        .bus_clk(clk), .quiesce(quiesce), .run_i(run0), .sym_i(sym), .sym_valid_i(sym_valid),
        .sym_ready_o(rdy0), .src_done_i(src_done), .pe_y_o(y0), .pe_y_valid_o(yv0),
        .pe_en_o(en0), .pe_score_i(scores), .sc_data_o(data0), .sc_wren_o(wren0),
        .sc_full_i(sc_full), .sc_empty_i(sc_empty), .eof_o(eof0)
    );

    sw_array_ctrl #(.DEPTH(4), .SCORE_W(16), .PE_LAT(2), .OUT_MODE(1)) u_dut1 (
        .bus_clk(clk), .quiesce(quiesce), .run_i(run1), .sym_i(sym), .sym_valid_i(sym_valid),
        .sym_ready_o(rdy1), .src_done_i(src_done), .pe_y_o(y1), .pe_y_valid_o(yv1),
        .pe_en_o(en1), .pe_score_i(scores), .sc_data_o(data1), .sc_wren_o(wren1),
        .sc_full_i(sc_full), .sc_empty_i(sc_empty), .eof_o(eof1)
    );

    // FIFO-side capture, half a cycle away from the active edge
    always @(negedge clk) begin
        if (wren0) words0.push_back(data0);
        if (wren1) words1.push_back(data1);
        if (yv0) ens0.push_back(en0);
        if (yv1) ens1.push_back(en1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_all();
        run0 = 1'b0; run1 = 1'b0; sym_valid = 1'b0; src_done = 1'b0;
        sc_full = 1'b0; sc_empty = 1'b1; sym = 2'd0;
        scores = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        tick(2);
        words0.delete(); words1.delete(); ens0.delete(); ens1.delete();
    endtask

    task automatic send_sym(input int which, input logic [1:0] s);
        int n = 0;
        sym = s;
        sym_valid = 1'b1;
        while ((((which == 0) ? rdy0 : rdy1) !== 1'b1) && (n < 200)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send_sym: dut%0d ready stayed 0, required 1 within 200 cycles", which);
        end
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic wait_words(input int which, input int n, input int limit, input string tag);
        int c = 0;
        while ((((which == 0) ? words0.size() : words1.size()) < n) && (c < limit)) begin
            tick();
            c++;
        end
        checks++;
        if (c >= limit) begin
            errors++;
            $display("FAIL %s: got %0d words, required %0d within %0d cycles", tag,
                     (which == 0) ? words0.size() : words1.size(), n, limit);
        end
    endtask

    task automatic check_stream(input string tag, input int exp_n);
        logic [31:0] exp_w;
        checks++;
        if (words0.size() != exp_n) begin
            errors++;
            $display("FAIL %s_count: got %0d words, required %0d", tag, words0.size(), exp_n);
        end
        for (int i = 0; i < words0.size(); i++) begin
            exp_w = 32'(32'h11 * ((i % 4) + 1));
            checks++;
            if (words0[i] !== exp_w) begin
                errors++;
                $display("FAIL %s_word%0d: got %h, required %h", tag, i, words0[i], exp_w);
            end
        end
    endtask

    task automatic test_reset();
        quiesce = 1'b1;
        idle_all();
        checks++;
        if ({rdy0, yv0, wren0, eof0, y0, en0, data0} !== '0) begin
            errors++;
            $display("FAIL reset_dut0: got %h, required 0", {rdy0, yv0, wren0, eof0, y0, en0, data0});
        end
        checks++;
        if ({rdy1, yv1, wren1, eof1, y1, en1, data1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got %h, required 0", {rdy1, yv1, wren1, eof1, y1, en1, data1});
        end
        quiesce = 1'b0;
        tick(2);
        checks++;
        if ({rdy0, yv0, wren0, eof0, en0} !== '0) begin
            errors++;
            $display("FAIL idle_no_run: got %h, required 0", {rdy0, yv0, wren0, eof0, en0});
        end
    endtask

    task automatic test_stream();
        logic [3:0] exp_en [7];
        exp_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        idle_all();
        sc_empty = 1'b0;
        run0 = 1'b1;
        send_sym(0, 2'd3);
        checks++;
        if ({en0, yv0, y0} !== {4'b0001, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL step1: got en=%b yv=%b y=%0d, required en=0001 yv=1 y=3", en0, yv0, y0);
        end
        checks++;
        if (wren0 !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got wren=%b, required 0", wren0);
        end
        tick();
        checks++;
        if ({wren0, data0} !== {1'b1, 32'h11}) begin
            errors++;
            $display("FAIL latency: got wren=%b data=%h, required 1 00000011", wren0, data0);
        end
        send_sym(0, 2'd1);
        send_sym(0, 2'd2);
        src_done = 1'b1;
        wait_words(0, 28, 400, "stream_wait");
        tick(3);
        check_stream("stream", 28);
        checks++;
        if (ens0.size() != 7) begin
            errors++;
            $display("FAIL en_steps: got %0d steps, required 7", ens0.size());
        end
        for (int i = 0; i < 7 && i < ens0.size(); i++) begin
            checks++;
            if (ens0[i] !== exp_en[i]) begin
                errors++;
                $display("FAIL en_step%0d: got %b, required %b", i, ens0[i], exp_en[i]);
            end
        end
        checks++;
        if (eof0 !== 1'b0) begin
            errors++;
            $display("FAIL eof_nonempty: got %b, required 0", eof0);
        end
        sc_empty = 1'b1;
        #1;
        checks++;
        if (eof0 !== 1'b1) begin
            errors++;
            $display("FAIL eof_empty: got %b, required 1", eof0);
        end
    endtask

    task automatic test_full_stall();
        int c = 0;
        idle_all();
        sc_empty = 1'b0;
        run0 = 1'b1;
        send_sym(0, 2'd3);
        while (words0.size() < 2 && c < 50) begin
            tick();
            c++;
        end
        sc_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (wren0 !== 1'b0) begin
                errors++;
                $display("FAIL stall_wren%0d: got %b, required 0", k, wren0);
            end
            tick();
        end
        sc_full = 1'b0;
        send_sym(0, 2'd1);
        send_sym(0, 2'd2);
        src_done = 1'b1;
        wait_words(0, 28, 400, "stall_wait");
        tick(3);
        check_stream("stall", 28);
    endtask

    task automatic test_out_mode();
        logic [3:0] exp_en [9];
        exp_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111,
                   4'b1110, 4'b1100, 4'b1000, 4'b0000};
        idle_all();
        run1 = 1'b1;
        for (int i = 0; i < 5; i++) send_sym(1, 2'(i));
        src_done = 1'b1;
        wait_words(1, 9, 400, "mode1_wait");
        tick(4);
        checks++;
        if (words1.size() != 9) begin
            errors++;
            $display("FAIL mode1_count: got %0d words, required 9", words1.size());
        end
        for (int i = 0; i < words1.size(); i++) begin
            checks++;
            if (words1[i] !== 32'h44) begin
                errors++;
                $display("FAIL mode1_word%0d: got %h, required 00000044", i, words1[i]);
            end
        end
        for (int i = 0; i < 9 && i < ens1.size(); i++) begin
            checks++;
            if (ens1[i] !== exp_en[i]) begin
                errors++;
                $display("FAIL mode1_en%0d: got %b, required %b", i, ens1[i], exp_en[i]);
            end
        end
        checks++;
        if ({eof1, eof0, 32'(words0.size())} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL mode1_eof: got eof1=%b eof0=%b w0=%0d, required 1 0 0",
                     eof1, eof0, words0.size());
        end
    endtask

    task automatic test_empty_session();
        int c = 0;
        int exp_n;
`ifdef SW_MAX_TRACK_EN
        exp_n = 1;
`else
        exp_n = 0;
`endif
        idle_all();
        src_done = 1'b1;
        run0 = 1'b1;
        while (eof0 !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (eof0 !== 1'b1) begin
            errors++;
            $display("FAIL empty_eof: got %b, required 1 within 20 cycles", eof0);
        end
        checks++;
        if (words0.size() != exp_n) begin
            errors++;
            $display("FAIL empty_words: got %0d, required %0d", words0.size(), exp_n);
        end
`ifdef SW_MAX_TRACK_EN
        checks++;
        if (words0.size() != 1 || words0[0] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL empty_max_word: got %0d words, required one 80000000", words0.size());
        end
`endif
    endtask

`ifdef SW_MAX_TRACK_EN
    task automatic test_max_track();
        idle_all();
        scores = {16'd0, 16'd3, 16'd19, 16'd7};
        run0 = 1'b1;
        send_sym(0, 2'd1);
        src_done = 1'b1;
        wait_words(0, 21, 400, "max_wait");
        tick(3);
        checks++;
        if (words0.size() != 21 || words0[words0.size()-1] !== 32'h8000_0013) begin
            errors++;
            $display("FAIL max_word: got %0d words last %h, required 21 last 80000013",
                     words0.size(), words0[words0.size()-1]);
        end
        checks++;
        if (eof0 !== 1'b1) begin
            errors++;
            $display("FAIL max_eof: got %b, required 1", eof0);
        end
    endtask
`endif

    task automatic test_abort();
        idle_all();
        run0 = 1'b1;
        send_sym(0, 2'd2);
        tick(2);
        run0 = 1'b0;
        #1;
        checks++;
        if (wren0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: got wren=%b, required 0", wren0);
        end
        tick();
        checks++;
        if ({rdy0, yv0, wren0, eof0, y0, en0, data0} !== '0 || words0.size() != 1) begin
            errors++;
            $display("FAIL abort_idle: got outs=%h words=%0d, required 0 and 1",
                     {rdy0, yv0, wren0, eof0, y0, en0, data0}, words0.size());
        end
        run0 = 1'b1;
        send_sym(0, 2'd1);
        checks++;
        if (en0 !== 4'b0001) begin
            errors++;
            $display("FAIL abort_ramp: got %b, required 0001", en0);
        end
        quiesce = 1'b1;
        #1;
        checks++;
        if ({rdy0, yv0, wren0, eof0, y0, en0, data0} !== '0) begin
            errors++;
            $display("FAIL quiesce_outs: got %h, required 0", {rdy0, yv0, wren0, eof0, y0, en0, data0});
        end
        tick();
        quiesce = 1'b0;
        words0.delete();
        send_sym(0, 2'd0);
        checks++;
        if (en0 !== 4'b0001) begin
            errors++;
            $display("FAIL restart_ramp: got %b, required 0001", en0);
        end
        wait_words(0, 4, 50, "restart_wait");
        tick(2);
        check_stream("restart", 4);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_out_mode();
        test_empty_session();
`ifdef SW_MAX_TRACK_EN
        test_max_track();
`endif
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule
